// File: rtl/mem_pkg.sv
// Shared types and default latencies for the main memory slice.
package mem_pkg;

  typedef logic [7:0] byte_t;
  // Index 0 is the most-significant byte.
  typedef byte_t [0:3] word_t;

  typedef enum logic {W_IDLE, W_WRITING} wstate_e;

  localparam int unsigned DEF_ADDR_BITS     = 16;
  localparam int unsigned DEF_READ_LATENCY  = 3;
  localparam int unsigned DEF_WRITE_LATENCY = 4;

  // Wide enough for WRITE_LATENCY-1 up to 3.
  localparam int unsigned WCNT_W = 3;

endpackage

// File: rtl/main_memory_if.sv
// Cache-to-memory bus. MEMORY_BOUNDS_CHECK_EN adds addr_error.
interface main_memory_if;
  import mem_pkg::*;

  logic [31:0] mem_addr;
  word_t       data_in;
  logic        mem_write_en;
  word_t       data_out;
  logic        read_valid;
  logic        write_busy;
`ifdef MEMORY_BOUNDS_CHECK_EN
  logic        addr_error;

  modport master (output mem_addr, data_in, mem_write_en,
                  input  data_out, read_valid, write_busy, addr_error);
  modport slave  (input  mem_addr, data_in, mem_write_en,
                  output data_out, read_valid, write_busy, addr_error);
`else
  modport master (output mem_addr, data_in, mem_write_en,
                  input  data_out, read_valid, write_busy);
  modport slave  (input  mem_addr, data_in, mem_write_en,
                  output data_out, read_valid, write_busy);
`endif
endinterface

// File: rtl/mem_read_pipe.sv
// Fixed-depth read data pipeline with a valid bit that fills after reset.
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  word_t word_i,
  output word_t word_o,
  output logic  valid_o
);

  word_t                   stage_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;

  // Shift the sampled word and a constant-1 valid token through the stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      stage_q[0] <= word_i;
      valid_q[0] <= 1'b1;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign word_o  = stage_q[READ_LATENCY-1];
  assign valid_o = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/main_memory.sv
// Big-endian byte-array main memory with free-running read pipeline and
// delayed write commit. MEMORY_BOUNDS_CHECK_EN rejects/zeroes accesses
// with nonzero address bits above ADDR_BITS and reports addr_error.
module main_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input logic         clk,
  input logic         reset,
  main_memory_if.slave mem
);

  localparam int unsigned IDX_W = ADDR_BITS - 2;

  byte_t             mem_q [2**ADDR_BITS];
  wstate_e           state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  word_t             wr_data_q, wr_data_d;

  logic [IDX_W-1:0]  rd_idx;
  logic              oor;
  logic              commit;
  word_t             rd_word;
  word_t             pipe_word;
  logic              pipe_valid;
  logic              unused_addr_bits;

  assign rd_idx = mem.mem_addr[ADDR_BITS-1:2];

`ifdef MEMORY_BOUNDS_CHECK_EN
  logic addr_error_q;

  assign oor              = |mem.mem_addr[31:ADDR_BITS];
  assign unused_addr_bits = ^mem.mem_addr[1:0];

  // Flag an out-of-range address one cycle after it is sampled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_error_q <= 1'b0;
    else        addr_error_q <= oor;
  end

  assign mem.addr_error = addr_error_q;
`else
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{mem.mem_addr[31:ADDR_BITS], mem.mem_addr[1:0]};
`endif

  assign commit = (state_q == W_WRITING) && (cnt_q == '0);

  // Array word at the current address, bypassed by a same-edge commit.
  always_comb begin
    rd_word = '0;
    if (!oor) begin
      for (int unsigned k = 0; k < 4; k++) begin
        rd_word[k] = mem_q[{rd_idx, 2'(k)}];
      end
      if (commit && (wr_idx_q == rd_idx)) rd_word = wr_data_q;
    end
  end

  // Write FSM next state: accept in IDLE, count down, commit at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    case (state_q)
      W_IDLE: begin
        if (mem.mem_write_en && !oor) begin
          wr_idx_d  = rd_idx;
          wr_data_d = mem.data_in;
          cnt_d     = WCNT_W'(WRITE_LATENCY - 1);
          state_d   = W_WRITING;
        end
      end
      W_WRITING: begin
        if (cnt_q == '0) state_d = W_IDLE;
        else             cnt_d   = cnt_q - WCNT_W'(1);
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; reset discards any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= W_IDLE;
      cnt_q     <= '0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Array storage keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem_q[{wr_idx_q, 2'(k)}] <= wr_data_q[k];
      end
    end
  end

  mem_read_pipe #(.READ_LATENCY(READ_LATENCY)) u_read_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .word_i (rd_word),
    .word_o (pipe_word),
    .valid_o(pipe_valid)
  );

  assign mem.data_out   = pipe_word;
  assign mem.read_valid = pipe_valid;
  assign mem.write_busy = (state_q == W_WRITING);

endmodule

// File: tb/tb_main_memory.sv
// Directed table-driven bench for main_memory (READ_LATENCY=3, WRITE_LATENCY=4).
module tb_main_memory;
  import mem_pkg::*;

  localparam int unsigned RL = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  main_memory_if bus ();

  main_memory #(.ADDR_BITS(16), .READ_LATENCY(RL), .WRITE_LATENCY(4)) dut (
    .clk  (clk),
    .reset(rst_n),
    .mem  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic        exp_busy;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic [31:0] addr, input logic we, input logic [31:0] din);
    @(negedge clk);
    bus.mem_addr     = addr;
    bus.mem_write_en = we;
    bus.data_in      = din;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] din);
    int n;
    step(addr, 1'b1, din);
    n = 0;
    while (bus.write_busy && n < 10) begin
      step(addr, 1'b0, 32'h0);
      n++;
    end
    check("write_done", {31'h0, bus.write_busy}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.mem_addr = 32'h100;
    bus.mem_write_en = 1'b0;
    bus.data_in = '0;

    //            addr          we    din            busy  out
    vecs[0]  = '{32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[1]  = '{32'h100, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[2]  = '{32'h104, 1'b1, 32'h11223344, 1'b1, 32'h0};
    vecs[3]  = '{32'h100, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{32'h100, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{32'h104, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{32'h104, 1'b1, 32'h11223344, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{32'h100, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{32'h104, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{32'h104, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[10] = '{32'h104, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{32'h100, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{32'h000, 1'b0, 32'h0,        1'b0, 32'h11223344};
    vecs[13] = '{32'h104, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};

    // Power-on reset and read_valid fill.
    #12;
    check("rst_data",  bus.data_out,   32'h0);
    check("rst_valid", {31'h0, bus.read_valid}, 32'h0);
    check("rst_busy",  {31'h0, bus.write_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check("fill_valid", {31'h0, bus.read_valid}, (e == 3) ? 32'h1 : 32'h0);
      if (e < 3) check("fill_data", bus.data_out, 32'h0);
    end

    // Known old contents for the words under test.
    write_word(32'h100, 32'h0);
    write_word(32'h104, 32'h0);
    write_word(32'h200, 32'h0);
    write_word(32'h008, 32'h0);
    for (int i = 0; i < 3; i++) step(32'h100, 1'b0, 32'h0);

    // Write occupancy, old-data reads, write-first bypass, ignored pulse, retry.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].addr, vecs[i].we, vecs[i].din);
      check($sformatf("vec%0d_busy", i), {31'h0, bus.write_busy}, {31'h0, vecs[i].exp_busy});
      check($sformatf("vec%0d_out", i), bus.data_out, vecs[i].exp_out);
    end
    check("byte0_msb", {24'h0, bus.data_out[0]}, 32'hDE);
    check("byte3_lsb", {24'h0, bus.data_out[3]}, 32'hEF);

`ifndef MEMORY_BOUNDS_CHECK_EN
    // Upper address bits wrap.
    write_word(32'h0001_0008, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) step(32'h0000_0008, 1'b0, 32'h0);
    check("wrap_read", bus.data_out, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) step(32'h0001_0100, 1'b0, 32'h0);
    check("wrap_alias", bus.data_out, 32'hDEADBEEF);
`else
    // Out-of-range write rejected, reads return zero.
    step(32'h0001_0008, 1'b1, 32'hCAFEF00D);
    check("oor_busy", {31'h0, bus.write_busy}, 32'h0);
    check("oor_err",  {31'h0, bus.addr_error}, 32'h1);
    step(32'h0000_0008, 1'b0, 32'h0);
    check("oor_err_clr", {31'h0, bus.addr_error}, 32'h0);
    for (int i = 0; i < 2; i++) step(32'h0000_0008, 1'b0, 32'h0);
    check("oor_wrap_read", bus.data_out, 32'h0);
    for (int i = 0; i < 3; i++) step(32'h0001_0100, 1'b0, 32'h0);
    check("oor_read_zero", bus.data_out, 32'h0);
`endif

    // Reset mid-write (counter at 2) discards the write.
    step(32'h200, 1'b1, 32'hAABBCCDD);
    step(32'h200, 1'b0, 32'h0);
    check("pre_rst_busy", {31'h0, bus.write_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'h0, bus.write_busy}, 32'h0);
    check("mid_rst_valid", {31'h0, bus.read_valid}, 32'h0);
    check("mid_rst_data",  bus.data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check("refill_valid", {31'h0, bus.read_valid}, (e == 3) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 6; i++) step(32'h200, 1'b0, 32'h0);
    check("discard_busy", {31'h0, bus.write_busy}, 32'h0);
    check("discard_data", bus.data_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
